seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Drives the 8-digit multiplexed seven-segment display that the reaction timer
//  reads back on An/CA..CG. Accepts a hex word through a valid/ready load port and
//  double-buffers it. Scans one digit at a time with active-low anodes, segments
//  and DP. Blanks between digits to stop ghosting. New data is committed only at
//  frame boundaries, so the display never tears.
// PARAMETERS
//  NUM_DIGITS  8        digits scanned; index 0 = rightmost
//  SCAN_DIV    100000   clk cycles per digit slot (>= BLANK_CYC+2)
//  BLANK_CYC   4        cycles at start of each slot with all anodes off
// PORTS
//  clk         in   1               system clock, rising edge
//  rst_n       in   1               async active-low reset
//  load_valid  in   1               load request
//  load_ready  out  1               high when no update is pending
//  load_data   in   4*NUM_DIGITS    hex nibbles; nibble i -> digit i
//  load_dp     in   NUM_DIGITS      decimal point per digit, 1 = lit
//  load_en     in   NUM_DIGITS      digit enable, 0 = digit blank
//  an          out  NUM_DIGITS      anodes, active-low
//  seg         out  7               {CG,CF,CE,CD,CC,CB,CA}, active-low
//  dp          out  1               decimal point, active-low
//  frame_done  out  1               1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  Reset (async, immediate): an='1, seg='1, dp=1, frame_done=0, load_ready=1,
//   active/pending regs=0, digit index=0, state BLANK, slot counter=0.
//  Handshake: accepted when load_valid&&load_ready. Capture into pending regs and
//   set pending. load_ready=!pending (registered); it drops the cycle after accept.
//  FSM per slot: BLANK (counter 0..BLANK_CYC-1, an='1, seg='1, dp=1) -> DRIVE
//   (counter BLANK_CYC..SCAN_DIV-1). At counter==SCAN_DIV-1: counter->0, state->BLANK,
//   index++.
//  DRIVE: an[index]=0 (others 1) if the digit is shown, else an='1. seg=hexdec(nibble),
//   dp=!dp_bit. All outputs are registered; they change 1 cycle after the state/index.
//  Wrap: at the end of slot NUM_DIGITS-1, index->0 and frame_done pulses. If pending,
//   pending regs copy to active and pending clears in that same cycle. load_ready
//   rises the next cycle. No accept can coincide with a commit.
//  hexdec (active-low, bit0=CA): 0=1000000 1=1111001 2=0100100 3=0110000
//   4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000
//   b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
//  load_en[i]=0 blanks the digit: anode off, seg='1, dp=1. The slot is still timed.
//  Reset mid-frame aborts the scan. A pending update is discarded.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digits from NUM_DIGITS-1 downward whose nibble is
//   0 are blanked until the first nonzero (or enabled-DP) digit. Digit 0 is never
//   blanked by this rule. Not defined: every enabled digit shows its value.
// STRUCTURE
//  Package seg7_pkg: 16-entry active-low segment table (localparam logic [6:0]),
//   scan-state enum {BLANK, DRIVE}, SEG_OFF='1 constant.
//  Sub-module seg7_hex_decode: combinational nibble->seg lookup using seg7_pkg.
//   Everything else is inline.
// TESTING (NUM_DIGITS=8, SCAN_DIV=10, BLANK_CYC=2)
//  1 Reset: assert rst_n=0 mid-DRIVE -> an=FF, seg=7F, dp=1, load_ready=1 in the same
//    cycle; a pending update is lost.
//  2 Load 32'h0123_4567, en=FF, dp=0 -> from the next frame, slot0 an=FE seg=1111000
//    ('7'), slot7 an=7F seg=1000000 ('0'). Each slot has 2 cycles of an=FF first.
//  3 Back-to-back loads: 2nd valid held high -> load_ready=0 until 1 cycle after the
//    frame_done commit. The 2nd word appears in the frame after it.
//  4 Frame timing: frame_done pulses exactly every 80 cycles, 1 cycle wide.
//  5 load_en=8'h0F, dp=8'h04 -> digits 4-7 never drive an anode; digit 2 has dp=0.
//  6 LEADING_ZERO_BLANK_EN with data 32'h0000_0000 -> only digit 0 is lit ('0').
//    Without the macro, all 8 digits show '0'.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared types and constants for the seven-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {CG,CF,CE,CD,CC,CB,CA}, indexed by hex value
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex_decode
// Purpose  : Combinational hex nibble to active-low segment pattern lookup.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Double-buffered, frame-synchronous multiplexed 7-segment scanner.
//            Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic [NUM_DIGITS-1:0]   load_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t            r_state;
    scan_state_t            w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;

    logic [4*NUM_DIGITS-1:0] r_act_data, r_pend_data;
    logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_act_en, r_pend_en;
    logic                    r_pending;
    logic                    r_ready;

    logic [NUM_DIGITS-1:0]   r_an, w_an_nxt;
    logic [6:0]              r_seg, w_seg_nxt;
    logic                    r_dp, w_dp_nxt;
    logic                    r_frame_done;

    logic                    w_slot_end, w_frame_end, w_accept;
    logic [3:0]              w_nib;
    logic [6:0]              w_hex_seg;
    logic [NUM_DIGITS-1:0]   w_lz_keep, w_show;

    assign w_slot_end  = (r_cnt == C_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == C_IDX_LAST);
    assign w_accept    = load_valid && r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BLANK;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BLANK:   if (r_cnt == C_BLANK_LAST) w_state_nxt = DRIVE;
            DRIVE:   if (w_slot_end)            w_state_nxt = BLANK;
            default: w_state_nxt = BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Accept and commit are mutually exclusive: ready is low while pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_act_en    <= '0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pend_en   <= '0;
            r_pending   <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            if (w_accept) begin
                r_pend_data <= load_data;
                r_pend_dp   <= load_dp;
                r_pend_en   <= load_en;
                r_pending   <= 1'b1;
                r_ready     <= 1'b0;
            end else begin
                r_ready     <= !r_pending;
            end
            if (w_frame_end && r_pending) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_act_en    <= r_pend_en;
                r_pending   <= 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_zero_run;
    always_comb begin
        w_lz_keep  = '1;
        w_zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (w_zero_run && (r_act_data[4*i +: 4] == 4'h0) && !r_act_dp[i])
                w_lz_keep[i] = 1'b0;
            else
                w_zero_run = 1'b0;
        end
    end
`else
    assign w_lz_keep = '1;
`endif

    assign w_show = r_act_en & w_lz_keep;
    assign w_nib  = r_act_data[4*r_idx +: 4];

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nib),
        .o_seg    (w_hex_seg)
    );

    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = 1'b1;
        if (r_state == DRIVE && w_show[r_idx]) begin
            w_an_nxt[r_idx] = 1'b0;
            w_seg_nxt       = w_hex_seg;
            w_dp_nxt        = !r_act_dp[r_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= '1;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_frame_done <= w_frame_end;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;
    assign load_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Directed self-checking bench for seg7_scan_driver (8 digits,
//            10-cycle slots, 2 blank cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic [7:0]  load_dp = '0;
    logic [7:0]  load_en = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] s_an  [8];
    logic [6:0] s_seg [8];
    logic       s_dp  [8];
    int         s_blank_bad, s_fd_bad, s_drive_bad;

    seg7_scan_driver #(
        .NUM_DIGITS (8),
        .SCAN_DIV   (10),
        .BLANK_CYC  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_en    (load_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        if (frame_done !== 1'b1) check("fd_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
        int n = 0;
        load_data  = d;
        load_dp    = p;
        load_en    = e;
        load_valid = 1'b1;
        while (load_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (load_ready !== 1'b1) check("load_timeout", 32'd0, 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Starts on the negedge where frame_done is high, ends on the next one.
    task automatic scan_frame();
        int k, o;
        s_blank_bad = 0;
        s_fd_bad    = 0;
        s_drive_bad = 0;
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            k = (t - 1) / 10;
            o = (t - 1) % 10;
            if (o < 2) begin
                if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) s_blank_bad++;
            end else if (o == 2) begin
                s_an[k]  = an;
                s_seg[k] = seg;
                s_dp[k]  = dp;
            end else if (an !== s_an[k] || seg !== s_seg[k] || dp !== s_dp[k]) begin
                s_drive_bad++;
            end
            if (t < 80 && frame_done !== 1'b0) s_fd_bad++;
        end
        check("fd_period", {31'd0, frame_done}, 32'd1);
        check("fd_extra", s_fd_bad, 0);
        check("blank_gap", s_blank_bad, 0);
        check("drive_steady", s_drive_bad, 0);
    endtask

    task automatic verify(input string name, input logic [31:0] d,
                          input logic [7:0] p, input logic [7:0] shown);
        logic [7:0] m;
        for (int k = 0; k < 8; k++) begin
            m = 8'h01 << k;
            if (shown[k]) begin
                check($sformatf("%s an%0d", name, k), {24'd0, s_an[k]}, {24'd0, ~m});
                check($sformatf("%s seg%0d", name, k), {25'd0, s_seg[k]}, {25'd0, hexseg(d[4*k +: 4])});
                check($sformatf("%s dp%0d", name, k), {31'd0, s_dp[k]}, {31'd0, ~p[k]});
            end else begin
                check($sformatf("%s an%0d", name, k), {24'd0, s_an[k]}, 32'hFF);
                check($sformatf("%s seg%0d", name, k), {25'd0, s_seg[k]}, 32'h7F);
                check($sformatf("%s dp%0d", name, k), {31'd0, s_dp[k]}, 32'd1);
            end
        end
    endtask

    initial begin
        logic [7:0] lz_shown;
        int bad, n;

        repeat (3) @(negedge clk);
        check("rst an", {24'd0, an}, 32'hFF);
        check("rst seg", {25'd0, seg}, 32'h7F);
        check("rst dp", {31'd0, dp}, 32'd1);
        check("rst ready", {31'd0, load_ready}, 32'd1);
        check("rst fd", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        wait_fd();

        // Basic load, committed at the next frame boundary
        do_load(32'h0123_4567, 8'h00, 8'hFF);
        wait_fd();
        scan_frame();
        verify("t2", 32'h0123_4567, 8'h00, 8'hFF);

        // Back-to-back loads with valid held high
        load_data  = 32'h89AB_CDEF;
        load_dp    = 8'h80;
        load_en    = 8'hFF;
        load_valid = 1'b1;
        @(negedge clk);
        load_data  = 32'h0F1E_2D3C;
        load_dp    = 8'h00;
        check("t3 ready_drop", {31'd0, load_ready}, 32'd0);
        bad = 0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
            if (frame_done !== 1'b1 && load_ready !== 1'b0) bad++;
        end while (frame_done !== 1'b1 && n < 200);
        check("t3 fd_seen", {31'd0, frame_done}, 32'd1);
        check("t3 ready_held", bad, 0);
        check("t3 ready_commit", {31'd0, load_ready}, 32'd0);
        fork
            scan_frame();
            begin
                @(negedge clk);
                check("t3 ready_rise", {31'd0, load_ready}, 32'd1);
                @(negedge clk);
                load_valid = 1'b0;
            end
        join
        verify("t3a", 32'h89AB_CDEF, 8'h80, 8'hFF);
        scan_frame();
        verify("t3b", 32'h0F1E_2D3C, 8'h00, 8'hFF);

        // Digit enables and decimal point
        do_load(32'h89AB_CDEF, 8'h04, 8'h0F);
        wait_fd();
        scan_frame();
        verify("t5", 32'h89AB_CDEF, 8'h04, 8'h0F);

        // All-zero word: leading-zero suppression when built in
`ifdef LEADING_ZERO_BLANK_EN
        lz_shown = 8'h01;
`else
        lz_shown = 8'hFF;
`endif
        do_load(32'h0000_0000, 8'h00, 8'hFF);
        wait_fd();
        scan_frame();
        verify("t6", 32'h0000_0000, 8'h00, lz_shown);

        // Async reset mid-DRIVE with an update pending
        do_load(32'h1111_1111, 8'h00, 8'hFF);
        repeat (3) @(negedge clk);
        check("t1 pre_rst_an", {24'd0, an}, 32'hFE);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1 an", {24'd0, an}, 32'hFF);
        check("t1 seg", {25'd0, seg}, 32'h7F);
        check("t1 dp", {31'd0, dp}, 32'd1);
        check("t1 ready", {31'd0, load_ready}, 32'd1);
        check("t1 fd", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fd();
        scan_frame();
        verify("t1 post", 32'h0, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
